// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-access controller and its address decoder.
package mem_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [1:0] SEL_M0   = 2'b00;
  localparam logic [1:0] SEL_M1   = 2'b01;
  localparam logic [1:0] SEL_M2   = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

endpackage

// File: rtl/mem_addr_decoder.sv
// Combinational region decode: base/size match per region, lowest region wins on overlap.
module mem_addr_decoder
  import mem_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] M0_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] M0_SIZE = 32'h0000_1000,
  parameter logic [ADDR_W-1:0] M1_BASE = 32'h0000_1000,
  parameter logic [ADDR_W-1:0] M1_SIZE = 32'h0000_1000,
  parameter logic [ADDR_W-1:0] M2_BASE = 32'h0000_2000,
  parameter logic [ADDR_W-1:0] M2_SIZE = 32'h0000_0100,
  parameter logic [2:0]        WR_MASK = 3'b110
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [1:0]        sel_o,
  output logic              writable_o
);

  logic hit_0, hit_1, hit_2;

  // Sizes are powers of two, so masking off the offset bits leaves the region base.
  assign hit_0 = (addr_i & ~(M0_SIZE - 32'd1)) == M0_BASE;
  assign hit_1 = (addr_i & ~(M1_SIZE - 32'd1)) == M1_BASE;
  assign hit_2 = (addr_i & ~(M2_SIZE - 32'd1)) == M2_BASE;

  always_comb begin
    hit_o      = 1'b1;
    sel_o      = SEL_NONE;
    writable_o = 1'b0;
    if (hit_0) begin
      sel_o      = SEL_M0;
      writable_o = WR_MASK[0];
    end else if (hit_1) begin
      sel_o      = SEL_M1;
      writable_o = WR_MASK[1];
    end else if (hit_2) begin
      sel_o      = SEL_M2;
      writable_o = WR_MASK[2];
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding memory-access controller: accepts one load/store, drives registered
// address/data/strobes to three regions and the read-mux selector, and pulses a response.
module mem_access_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned       READ_LAT = 1,
  parameter logic [ADDR_W-1:0] M0_BASE  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] M0_SIZE  = 32'h0000_1000,
  parameter logic [ADDR_W-1:0] M1_BASE  = 32'h0000_1000,
  parameter logic [ADDR_W-1:0] M1_SIZE  = 32'h0000_1000,
  parameter logic [ADDR_W-1:0] M2_BASE  = 32'h0000_2000,
  parameter logic [ADDR_W-1:0] M2_SIZE  = 32'h0000_0100,
  parameter logic [2:0]        WR_MASK  = 3'b110
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] wdata_out,
  output logic              we_0,
  output logic              we_1,
  output logic              we_2,
  output logic [1:0]        MemorySelector,
  output logic              rsp_valid,
  output logic              rsp_err
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT - 1);

  state_t     state_q;
  logic [2:0] cnt_q;

  logic       dec_hit;
  logic [1:0] dec_sel;
  logic       dec_writable;

  mem_addr_decoder #(
    .M0_BASE (M0_BASE),
    .M0_SIZE (M0_SIZE),
    .M1_BASE (M1_BASE),
    .M1_SIZE (M1_SIZE),
    .M2_BASE (M2_BASE),
    .M2_SIZE (M2_SIZE),
    .WR_MASK (WR_MASK)
  ) u_decoder (
    .addr_i     (req_addr),
    .hit_o      (dec_hit),
    .sel_o      (dec_sel),
    .writable_o (dec_writable)
  );

  assign req_ready = (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      addr_out       <= '0;
      wdata_out      <= '0;
      we_0           <= 1'b0;
      we_1           <= 1'b0;
      we_2           <= 1'b0;
      MemorySelector <= SEL_NONE;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
    end else begin
      // Strobes and response are single-cycle pulses unless re-asserted below.
      we_0      <= 1'b0;
      we_1      <= 1'b0;
      we_2      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_out       <= req_addr;
            wdata_out      <= req_wdata;
            MemorySelector <= dec_hit ? dec_sel : SEL_NONE;
            if (!dec_hit || (req_we && !dec_writable)) begin
              state_q   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (req_we) begin
              state_q   <= RESP;
              rsp_valid <= 1'b1;
              we_0      <= (dec_sel == SEL_M0);
              we_1      <= (dec_sel == SEL_M1);
              we_2      <= (dec_sel == SEL_M2);
            end else if (READ_LAT == 0) begin
              state_q   <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= LAT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q   <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (READ_LAT 1, 3, 0) checked every cycle against a
// transaction-level model, plus directed literal checks.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv    [3];
  logic        rwe   [3];
  logic [31:0] raddr [3];
  logic [31:0] rwd   [3];
  logic        rdy   [3];
  logic [31:0] ao    [3];
  logic [31:0] wo    [3];
  logic        w0    [3];
  logic        w1    [3];
  logic        w2    [3];
  logic [1:0]  sel   [3];
  logic        rspv  [3];
  logic        rspe  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_ctrl #(
      .READ_LAT (g == 0 ? 1 : (g == 1 ? 3 : 0))
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (rv[g]),
      .req_ready      (rdy[g]),
      .req_we         (rwe[g]),
      .req_addr       (raddr[g]),
      .req_wdata      (rwd[g]),
      .addr_out       (ao[g]),
      .wdata_out      (wo[g]),
      .we_0           (w0[g]),
      .we_1           (w1[g]),
      .we_2           (w2[g]),
      .MemorySelector (sel[g]),
      .rsp_valid      (rspv[g]),
      .rsp_err        (rspe[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- Transaction-level model ----------------
  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
  endfunction

  // Region index by address range, -1 when unmapped.
  function automatic int region_of(input logic [31:0] a);
    if (a < 32'h0000_1000) return 0;
    if (a < 32'h0000_2000) return 1;
    if (a < 32'h0000_2100) return 2;
    return -1;
  endfunction

  logic [2:0]  wr_mask = 3'b110;
  int          cyc = 0;
  bit          model_ok = 0;
  bit          have [3] = '{0, 0, 0};
  int          ta   [3];
  int          off  [3];
  int          hitk [3];
  bit          st   [3];
  bit          err  [3];
  logic [31:0] maddr [3] = '{0, 0, 0};
  logic [31:0] mwd   [3] = '{0, 0, 0};
  int          pulses [3] = '{0, 0, 0};

  function automatic bit exp_ready(input int i);
    return !have[i] || (cyc >= ta[i] + off[i] + 1);
  endfunction

  function automatic bit exp_rsp(input int i);
    return have[i] && (cyc == ta[i] + off[i]);
  endfunction

  function automatic bit exp_we(input int i, input int k);
    return have[i] && st[i] && !err[i] && (hitk[i] == k) && (cyc == ta[i] + 1);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        have[i]  = 0;
        maddr[i] = '0;
        mwd[i]   = '0;
      end else if (rv[i] && exp_ready(i)) begin
        have[i]  = 1;
        ta[i]    = cyc;
        st[i]    = rwe[i];
        hitk[i]  = region_of(raddr[i]);
        maddr[i] = raddr[i];
        mwd[i]   = rwd[i];
        err[i]   = (hitk[i] < 0) || (rwe[i] && (wr_mask[hitk[i]] == 1'b0));
        off[i]   = (!err[i] && !rwe[i]) ? 1 + lat_of(i) : 1;
      end
    end
    if (rst) model_ok = 1;
    cyc++;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rspv[i] === 1'b1) pulses[i]++;
      if (model_ok) begin
        check($sformatf("i%0d req_ready", i), 32'(rdy[i]), 32'(exp_ready(i)));
        check($sformatf("i%0d rsp_valid", i), 32'(rspv[i]), 32'(exp_rsp(i)));
        check($sformatf("i%0d rsp_err", i), 32'(rspe[i]), 32'(exp_rsp(i) && err[i]));
        check($sformatf("i%0d we_0", i), 32'(w0[i]), 32'(exp_we(i, 0)));
        check($sformatf("i%0d we_1", i), 32'(w1[i]), 32'(exp_we(i, 1)));
        check($sformatf("i%0d we_2", i), 32'(w2[i]), 32'(exp_we(i, 2)));
        check($sformatf("i%0d sel", i), 32'(sel[i]),
              (have[i] && hitk[i] >= 0) ? 32'(hitk[i]) : 32'd3);
        check($sformatf("i%0d addr_out", i), ao[i], maddr[i]);
        check($sformatf("i%0d wdata_out", i), wo[i], mwd[i]);
      end
    end
  end

  // Read-data mux downstream of the controller; region data are arbitrary nonzero constants.
  function automatic logic [31:0] mux_out(input logic [1:0] s);
    case (s)
      2'b00:   return 32'h1111_1111;
      2'b01:   return 32'h2222_2222;
      2'b10:   return 32'h3333_3333;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- Directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int snap;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rv[i] = 0; rwe[i] = 0; raddr[i] = '0; rwd[i] = '0;
    end
    tick();
    tick();
    check("reset ready", 32'(rdy[0]), 32'd1);
    check("reset sel", 32'(sel[0]), 32'd3);
    check("reset addr_out", ao[0], 32'd0);
    rst = 1'b0;

    // Load 0x10, READ_LAT=1
    rv[0] = 1; rwe[0] = 0; raddr[0] = 32'h0000_0010; rwd[0] = 32'h0;
    tick(); rv[0] = 0;
    check("ld sel T+1", 32'(sel[0]), 32'd0);
    check("ld ready T+1", 32'(rdy[0]), 32'd0);
    check("ld rsp T+1", 32'(rspv[0]), 32'd0);
    tick();
    check("ld rsp T+2", 32'(rspv[0]), 32'd1);
    check("ld err T+2", 32'(rspe[0]), 32'd0);
    check("ld ready T+2", 32'(rdy[0]), 32'd0);
    check("ld mux T+2", mux_out(sel[0]), 32'h1111_1111);
    tick();
    check("ld ready T+3", 32'(rdy[0]), 32'd1);

    // Store 0x1008 <- DEADBEEF
    rv[0] = 1; rwe[0] = 1; raddr[0] = 32'h0000_1008; rwd[0] = 32'hDEAD_BEEF;
    tick(); rv[0] = 0; rwd[0] = 32'h0;
    check("st we_1 T+1", 32'(w1[0]), 32'd1);
    check("st wdata", wo[0], 32'hDEAD_BEEF);
    check("st addr", ao[0], 32'h0000_1008);
    check("st rsp T+1", 32'(rspv[0]), 32'd1);
    check("st err T+1", 32'(rspe[0]), 32'd0);
    tick();
    check("st we_1 T+2", 32'(w1[0]), 32'd0);

    // Store to read-only region 0
    rv[0] = 1; rwe[0] = 1; raddr[0] = 32'h0000_0004; rwd[0] = 32'h1234_5678;
    tick(); rv[0] = 0;
    check("ro we", {29'd0, w0[0], w1[0], w2[0]}, 32'd0);
    check("ro rsp", 32'(rspv[0]), 32'd1);
    check("ro err", 32'(rspe[0]), 32'd1);
    tick();

    // Unmapped load
    rv[0] = 1; rwe[0] = 0; raddr[0] = 32'h0000_3000;
    tick(); rv[0] = 0;
    check("miss sel", 32'(sel[0]), 32'd3);
    check("miss rsp", 32'(rspv[0]), 32'd1);
    check("miss err", 32'(rspe[0]), 32'd1);
    check("miss mux", mux_out(sel[0]), 32'd0);
    tick();

    // Reset mid-WAIT, READ_LAT=3
    rv[1] = 1; rwe[1] = 0; raddr[1] = 32'h0000_1004;
    tick(); rv[1] = 0;
    check("wait ready T+1", 32'(rdy[1]), 32'd0);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    check("abort ready", 32'(rdy[1]), 32'd1);
    check("abort sel", 32'(sel[1]), 32'd3);
    check("abort rsp", 32'(rspv[1]), 32'd0);
    snap = pulses[1];
    repeat (6) tick();
    check("abort no rsp", 32'(pulses[1] - snap), 32'd0);

    // Back-to-back loads, READ_LAT=0, req_valid held
    snap = pulses[2];
    rv[2] = 1; rwe[2] = 0; raddr[2] = 32'h0000_2000;
    tick();
    check("b2b sel 1st", 32'(sel[2]), 32'd2);
    check("b2b ready T+1", 32'(rdy[2]), 32'd0);
    raddr[2] = 32'h0000_1000;
    tick();
    check("b2b ready T+2", 32'(rdy[2]), 32'd1);
    tick(); rv[2] = 0;
    check("b2b sel 2nd", 32'(sel[2]), 32'd1);
    check("b2b rsp 2nd", 32'(rspv[2]), 32'd1);
    repeat (3) tick();
    check("b2b pulses", 32'(pulses[2] - snap), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
